// File: rtl/integrated_demod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : integrated_demod_pkg
// Description : Shared types and constants for the multi-mode demodulator:
//               the mode encoding, the one-hot LED patterns, the datapath
//               widths and a 16-bit signed saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package integrated_demod_pkg;

    localparam int c_SAMPLE_W = 8;
    localparam int c_RESULT_W = 16;

    typedef enum logic [1:0] {
        MODE_AM   = 2'b00,
        MODE_BPSK = 2'b01,
        MODE_FM   = 2'b10,
        MODE_INV  = 2'b11
    } mode_e;

    localparam logic [2:0] c_LED_AM   = 3'b001;
    localparam logic [2:0] c_LED_BPSK = 3'b010;
    localparam logic [2:0] c_LED_FM   = 3'b100;
    localparam logic [2:0] c_LED_OFF  = 3'b000;

    // Clamp an 18-bit signed accumulator into the signed 16-bit range.
    function automatic logic [c_RESULT_W-1:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'h7FFF;
        end else if (v < -18'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/integrated_demod_if.sv
`default_nettype none
// ============================================================================
// Module      : integrated_demod_if
// Description : Sample/result bus between the ADC side and the demodulator.
//               master : ADC side, drives samples and mode, observes results
//               slave  : demodulator, consumes samples, drives results/LEDs
// Revision    : 1.0 - initial release
// ============================================================================
interface integrated_demod_if;
    import integrated_demod_pkg::*;

    logic [c_SAMPLE_W-1:0] data_in;
    logic                  data_valid;
    logic [1:0]            mode_select;
    logic [c_RESULT_W-1:0] data_out;
    logic                  data_out_valid;
    logic [2:0]            status_led;

    modport master (
        output data_in, data_valid, mode_select,
        input  data_out, data_out_valid, status_led
    );

    modport slave (
        input  data_in, data_valid, mode_select,
        output data_out, data_out_valid, status_led
    );

endinterface
`default_nettype wire

// File: rtl/demod_nco.sv
`default_nettype none
// ============================================================================
// Module      : demod_nco
// Description : 32-bit phase accumulator producing a square-wave carrier sign.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : advance phase by PHASE_INC (after the current phase is used)
//   i_clr      : synchronous clear, has priority over i_en
//   o_neg      : carrier sign, 1 = carrier is -1 (phase[31])
// Revision    : 1.0 - initial release
// ============================================================================
module demod_nco #(
    parameter logic [31:0] PHASE_INC = 32'h0000_1000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_en,
    input  wire  i_clr,
    output logic o_neg
);

    logic [31:0] r_phase_q;
    logic [31:0] w_phase_d;

    always_comb begin
        w_phase_d = r_phase_q;
        if (i_clr) begin
            w_phase_d = '0;
        end else if (i_en) begin
            w_phase_d = r_phase_q + PHASE_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_q <= '0;
        end else begin
            r_phase_q <= w_phase_d;
        end
    end

    assign o_neg = r_phase_q[31];

endmodule
`default_nettype wire

// File: rtl/integrated_demod.sv
`default_nettype none
// ============================================================================
// Module      : integrated_demod
// Description : Multi-mode demodulator for 8-bit offset-binary samples:
//               AM envelope IIR, BPSK integrate-and-dump against an internal
//               NCO, FM delay-multiply. Two-stage pipeline (register sample,
//               then compute/register result).
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : data_in/data_valid/mode_select in,
//                        data_out/data_out_valid/status_led out
// Revision    : 1.0 - initial release
// ============================================================================
module integrated_demod
    import integrated_demod_pkg::*;
#(
    parameter int          AM_SHIFT      = 2,
    parameter logic [31:0] NCO_PHASE_INC = 32'h0000_1000,
    parameter int          SYM_LEN       = 8,
    parameter int          FM_DELAY      = 1
) (
    input wire                sys_clk,
    input wire                sys_rst_n,
    integrated_demod_if.slave bus
);

    localparam int c_CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;

    mode_e                    r_mode_q;
    logic                     w_mode_chg;
    logic signed [7:0]        w_s;
    logic signed [7:0]        r_s_q,  w_s_d;
    logic                     r_v1_q, w_v1_d;
    logic signed [16:0]       r_y_q,  w_y_d;
    logic signed [17:0]       r_acc_q, w_acc_d;
    logic [c_CNT_W-1:0]       r_cnt_q, w_cnt_d;
    logic signed [7:0]        r_dly_q [FM_DELAY];
    logic signed [7:0]        w_dly_d [FM_DELAY];
    logic [c_RESULT_W-1:0]    r_dout_q, w_dout_d;
    logic                     r_dval_q, w_dval_d;
    logic                     w_nco_en;
    logic                     w_nco_neg;
    logic signed [8:0]        w_s9, w_abs9, w_bp;
    logic signed [16:0]       w_x, w_diff, w_y_new;
    logic signed [17:0]       w_acc_sum;
    logic signed [15:0]       w_fm_prod;
    logic [2:0]               w_led;

    // A mode change clears every piece of demod state in the same cycle the
    // new mode is captured; samples entering or in flight are dropped.
    assign w_mode_chg = (mode_e'(bus.mode_select) != r_mode_q);
    assign w_s        = $signed(bus.data_in ^ 8'h80);

    // Stage 1: capture the converted sample.
    always_comb begin
        w_s_d  = bus.data_valid ? w_s : r_s_q;
        w_v1_d = bus.data_valid && !w_mode_chg && (r_mode_q != MODE_INV);
    end

    // Stage 2 datapath pieces.
    assign w_s9      = {r_s_q[7], r_s_q};
    assign w_abs9    = w_s9[8] ? -w_s9 : w_s9;       // 0..128, sign bit always 0
    assign w_x       = {w_abs9, 8'h00};
    assign w_diff    = w_x - r_y_q;
    assign w_y_new   = r_y_q + (w_diff >>> AM_SHIFT);
    assign w_bp      = w_nco_neg ? -w_s9 : w_s9;
    assign w_acc_sum = r_acc_q + {{9{w_bp[8]}}, w_bp};
    assign w_fm_prod = r_s_q * r_dly_q[FM_DELAY-1];

    always_comb begin
        w_y_d    = r_y_q;
        w_acc_d  = r_acc_q;
        w_cnt_d  = r_cnt_q;
        w_dly_d  = r_dly_q;
        w_dout_d = r_dout_q;
        w_dval_d = 1'b0;
        w_nco_en = 1'b0;
        if (w_mode_chg) begin
            w_y_d   = '0;
            w_acc_d = '0;
            w_cnt_d = '0;
            for (int i = 0; i < FM_DELAY; i++) begin
                w_dly_d[i] = '0;
            end
        end else if (r_v1_q) begin
            case (r_mode_q)
                MODE_AM: begin
                    w_y_d    = w_y_new;
                    w_dout_d = w_y_new[15:0];
                    w_dval_d = 1'b1;
                end
                MODE_BPSK: begin
                    w_nco_en = 1'b1;
                    if (r_cnt_q == c_CNT_W'(SYM_LEN - 1)) begin
                        w_dout_d = sat16(w_acc_sum);
                        w_dval_d = 1'b1;
                        w_acc_d  = '0;
                        w_cnt_d  = '0;
                    end else begin
                        w_acc_d  = w_acc_sum;
                        w_cnt_d  = r_cnt_q + c_CNT_W'(1);
                    end
                end
                MODE_FM: begin
                    w_dout_d   = w_fm_prod;
                    w_dval_d   = 1'b1;
                    w_dly_d[0] = r_s_q;
                    for (int i = 1; i < FM_DELAY; i++) begin
                        w_dly_d[i] = r_dly_q[i-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode_q <= MODE_INV;
            r_s_q    <= '0;
            r_v1_q   <= 1'b0;
            r_y_q    <= '0;
            r_acc_q  <= '0;
            r_cnt_q  <= '0;
            for (int i = 0; i < FM_DELAY; i++) begin
                r_dly_q[i] <= '0;
            end
            r_dout_q <= '0;
            r_dval_q <= 1'b0;
        end else begin
            r_mode_q <= mode_e'(bus.mode_select);
            r_s_q    <= w_s_d;
            r_v1_q   <= w_v1_d;
            r_y_q    <= w_y_d;
            r_acc_q  <= w_acc_d;
            r_cnt_q  <= w_cnt_d;
            r_dly_q  <= w_dly_d;
            r_dout_q <= w_dout_d;
            r_dval_q <= w_dval_d;
        end
    end

    demod_nco #(
        .PHASE_INC (NCO_PHASE_INC)
    ) u_nco (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_en  (w_nco_en),
        .i_clr (w_mode_chg),
        .o_neg (w_nco_neg)
    );

    always_comb begin
        case (r_mode_q)
            MODE_AM:   w_led = c_LED_AM;
            MODE_BPSK: w_led = c_LED_BPSK;
            MODE_FM:   w_led = c_LED_FM;
            default:   w_led = c_LED_OFF;
        endcase
    end

    assign bus.data_out       = r_dout_q;
    assign bus.data_out_valid = r_dval_q;
    assign bus.status_led     = w_led;

endmodule
`default_nettype wire

// File: tb/tb_integrated_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_integrated_demod
// Description : Scoreboard bench for integrated_demod. Stimulus pushes the
//               hand-computed result and the cycle it must appear on; a
//               monitor pops and compares on every data_out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integrated_demod;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    exp_t q[$];

    integrated_demod_if bus();

    integrated_demod dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation in value and cycle.
    always @(negedge sys_clk) begin
        if (bus.data_out_valid === 1'b1) begin
            exp_t e;
            strobes++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe got=0x%0h expected=none", bus.data_out);
            end else begin
                e = q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at posedge+1; the sample is taken on the next rising edge.
    task automatic send(input logic [7:0] d, input bit push, input logic [15:0] exp);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        if (push) q.push_back('{data: exp, cyc: cyc + 2});
        @(posedge sys_clk);
        #1;
        bus.data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        bus.mode_select = m;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        bus.data_in     = 8'hFF;
        bus.data_valid  = 1'b0;
        bus.mode_select = 2'b00;

        // Reset with strobes active: nothing may come out.
        repeat (4) begin
            @(posedge sys_clk);
            #1;
            bus.data_valid = ~bus.data_valid;
        end
        bus.data_valid = 1'b0;
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_valid", 32'(bus.data_out_valid), 32'h0);
        check("rst_led", 32'(bus.status_led), 32'h0);
        sys_rst_n = 1'b1;
        check("led_before_edge", 32'(bus.status_led), 32'h0);
        idle(1);
        check("led_am", 32'(bus.status_led), 32'h1);
        idle(2);

        // AM: |-64|<<8 = 0x4000 -> y=0x1000; |-63|<<8 -> 0x1BC0.
        send(8'h40, 1'b1, 16'h1000);
        idle(9);
        send(8'h41, 1'b1, 16'h1BC0);
        idle(9);

        // BPSK: samples 0..9 back-to-back, one dump of 0+..+7 = 28.
        set_mode(2'b01);
        check("led_bpsk", 32'(bus.status_led), 32'h2);
        for (int i = 0; i < 10; i++) begin
            send(8'h80 + 8'(i), i == 7, 16'h001C);
        end
        idle(6);

        // FM: delay line cleared by the mode change.
        set_mode(2'b10);
        check("led_fm", 32'(bus.status_led), 32'h4);
        send(8'hC0, 1'b1, 16'h0000);
        idle(3);
        send(8'hC1, 1'b1, 16'h1040);
        idle(4);

        // Invalid mode: samples ignored, output held.
        set_mode(2'b11);
        check("led_inv", 32'(bus.status_led), 32'h0);
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            send(8'(i * 13), 1'b0, 16'h0);
        end
        idle(4);
        check("inv_strobes", 32'(strobes - s0), 32'h0);
        check("inv_hold", 32'(bus.data_out), 32'h1040);

        // Mid-symbol switch: 4 samples of +16 must be discarded.
        set_mode(2'b01);
        for (int i = 0; i < 4; i++) begin
            send(8'h90, 1'b0, 16'h0);
        end
        set_mode(2'b10);
        set_mode(2'b01);
        for (int i = 1; i <= 8; i++) begin
            send(8'h80 + 8'(i), i == 8, 16'h0024);
        end
        idle(3);
        // Next symbol, negative samples: 8 * -16 = -128.
        for (int i = 0; i < 8; i++) begin
            send(8'h70, i == 7, 16'hFF80);
        end
        idle(6);
        check("bpsk_hold", 32'(bus.data_out), 32'hFF80);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/integrated_demod.md
Name: integrated_demod

Overview:
- Top-level multi-mode demodulator for 8-bit offset-binary samples.
- Selects AM envelope detection, BPSK integrate-and-dump against an internal square-wave NCO carrier, or FM delay-multiply detection via mode_select.
- Emits 16-bit results with a valid strobe and drives three mode LEDs.
- Sits between the ADC sample interface and downstream data handling.

Parameters:
AM_SHIFT, 2, IIR smoothing shift K for the AM envelope filter (1..8)
NCO_PHASE_INC, 32'h0000_1000, 32-bit NCO phase increment applied per accepted sample
SYM_LEN, 8, samples per BPSK integrate-and-dump symbol (2..256)
FM_DELAY, 1, sample delay D for the FM delay-multiply detector (1..8)

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst_n  in  1  asynchronous, active-low reset
data_in  in  8  offset-binary sample; 0x80 = zero
data_valid  in  1  one-cycle strobe; data_in is sampled when high
mode_select  in  2  00 = AM, 01 = BPSK, 10 = FM, 11 = invalid
data_out  out  16  demodulated result, signed two's complement except AM, which is unsigned
data_out_valid  out  1  one-cycle strobe qualifying data_out
status_led  out  3  one-hot mode indicator

Behaviour:
- Interface: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n).
- Reset clears all state: data_out = 0, data_out_valid = 0, status_led = 0, NCO phase = 0, accumulators, filters, delay line and counters = 0, registered mode = 11.
- mode_select is registered every cycle.
- If the registered mode differs from the incoming mode, all demod state is cleared in that cycle (the same clear as reset, except outputs hold). Any sample in flight in that cycle is dropped.
- Input conversion: s = signed(data_in ^ 8'h80), range -128..127.
- Pipeline stage 1, on a data_valid cycle: register s.
- Pipeline stage 2: compute the result.
- data_out_valid pulses exactly 2 cycles after the accepted data_valid, except in BPSK mode, which pulses only on symbol dump.
- data_out holds its last value between strobes.
- Back-to-back data_valid every cycle must be supported (fully pipelined).
- AM (00):
  - a = |s| (0..128), x = a << 8.
  - y <= y + ((x - y) >>> AM_SHIFT), using 17-bit signed internal arithmetic.
  - data_out = y[15:0]; output every sample.
- BPSK (01):
  - NCO phase += NCO_PHASE_INC on each accepted sample, applied after use.
  - Carrier c = +1 when phase[31] = 0, else -1.
  - acc += s*c. A sample counter counts 0..SYM_LEN-1.
  - When the counter wraps: data_out = acc including the current sample, saturated to the signed 16-bit range; strobe; acc cleared; counter reset to 0.
- FM (10):
  - A delay line of FM_DELAY samples, reset to 0.
  - data_out = s[n] * s[n-FM_DELAY], a 16-bit signed product (max 16384, no overflow); output every sample.
- Invalid (11): samples are ignored; data_out_valid stays 0; data_out holds its value.
- status_led: AM = 001, BPSK = 010, FM = 100, invalid = 000. Driven from the registered mode, so it updates 1 cycle after mode_select changes.
- data_valid asserted during reset has no effect.
- Reset mid-symbol discards the partial BPSK accumulation.

Decomposition:
- Shared package: mode enum (MODE_AM = 2'b00, MODE_BPSK = 2'b01, MODE_FM = 2'b10, MODE_INV = 2'b11), LED one-hot constants, sample/result width constants (8, 16).
- One sub-module, demod_nco: a 32-bit phase accumulator with an enable and synchronous clear; outputs the carrier sign (phase[31]).
- The three detectors stay inline in integrated_demod, with a final output mux.

Test Plan:
- Reset, release, idle, default parameters:
  - data_out = 0, data_out_valid = 0, status_led = 000 while in reset.
  - After release with mode_select = 00, status_led = 001 one cycle later.
- AM, samples 0x40 then 0x41, one strobe per 10 cycles:
  - Outputs 0x1000, then 0x1BC0.
  - Each data_out_valid lands exactly 2 cycles after its data_valid.
- BPSK, samples 0x80..0x89:
  - Exactly one strobe, after the 8th sample, with data_out = 0x001C (sum of 0..7).
  - Samples 8 and 9 remain in the accumulator with no further strobe.
- FM, mode switched to 10, samples 0xC0 then 0xC1:
  - First output 0x0000 (delay line cleared on mode change).
  - Second output 0x1040 (65*64).
- Invalid mode 11 with 20 cycles of strobed samples:
  - No data_out_valid; status_led = 000; data_out unchanged.
- Mode switched mid-BPSK symbol (after 4 samples) to FM and back to BPSK:
  - The accumulator restarts.
  - The next BPSK strobe appears after 8 new samples and reflects only their sum.
